// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding, mode constants and width helper for the SPI master
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } spi_state_e;

  // CPHA value for which the leading SCLK edge is the sample edge
  localparam bit SPI_CPHA_SAMPLE_LEAD = 1'b0;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - SCLK divider: half-period tick, lead/trail edge strobes and sclk level
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2,
  parameter bit CPOL    = 1'b0
) (
  input  logic sys_clk,
  input  logic rstn,
  input  logic run,
  input  logic shift_en,
  output logic tick,
  output logic lead,
  output logic trail,
  output logic first_edge,
  output logic last_edge,
  output logic sclk
);

  localparam int DIV_W  = clog2_min1(CLK_DIV + 1);
  localparam int EDGE_W = clog2_min1(2 * DATA_W + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

  logic [DIV_W-1:0]  div_q, div_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic              sclk_q, sclk_d;

  // The divider runs through SETUP/SHIFT/HOLD so the FSM can time every phase off one tick
  assign tick       = run && (div_q == DIV_LAST);
  assign lead       = shift_en && tick && !edge_q[0];
  assign trail      = shift_en && tick && edge_q[0];
  assign first_edge = shift_en && tick && (edge_q == '0);
  assign last_edge  = shift_en && tick && (edge_q == EDGE_LAST);
  assign sclk       = sclk_q;

  always_comb begin
    div_d  = div_q;
    edge_d = edge_q;
    sclk_d = sclk_q;
    if (!run || tick) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end
    if (!shift_en) begin
      edge_d = '0;
      sclk_d = CPOL;
    end else if (tick) begin
      edge_d = (edge_q == EDGE_LAST) ? '0 : edge_q + 1'b1;
      sclk_d = ~sclk_q;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      div_q  <= '0;
      edge_q <= '0;
      sclk_q <= CPOL;
    end else begin
      div_q  <= div_d;
      edge_q <= edge_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI master: stream-in word, MSB-first shift on divided SCLK, captured word out
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int N_CS    = 4,
  parameter int CLK_DIV = 2,
  parameter bit CPOL    = 1'b0,
  parameter bit CPHA    = 1'b0
) (
  input  logic                        sys_clk,
  input  logic                        rstn,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  input  logic [DATA_W-1:0]           tx_data,
  input  logic [clog2_min1(N_CS)-1:0] cs_sel,
  output logic                        rx_valid,
  output logic [DATA_W-1:0]           rx_data,
  output logic                        busy,
  output logic                        sclk,
  output logic                        mosi,
  input  logic                        miso,
  output logic [N_CS-1:0]             cs_n
);

  localparam int CS_W = clog2_min1(N_CS);

  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [CS_W-1:0]   cs_q, cs_d;
  logic              run, shift_en, tick, lead, trail, first_edge, last_edge;
  logic              sample, shift;
  logic [N_CS-1:0]   cs_dec;

  assign run      = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);
  assign shift_en = (state_q == ST_SHIFT);

  spi_clk_gen #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV),
    .CPOL    (CPOL)
  ) u_clk_gen (
    .sys_clk    (sys_clk),
    .rstn       (rstn),
    .run        (run),
    .shift_en   (shift_en),
    .tick       (tick),
    .lead       (lead),
    .trail      (trail),
    .first_edge (first_edge),
    .last_edge  (last_edge),
    .sclk       (sclk)
  );

  // With CPHA=1 the MSB is already on mosi, so the first leading edge must not shift
  assign sample = (CPHA == SPI_CPHA_SAMPLE_LEAD) ? lead  : trail;
  assign shift  = (CPHA == SPI_CPHA_SAMPLE_LEAD) ? trail : (lead && !first_edge);

  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < N_CS; i++) begin
      if (run && (32'(cs_q) == i)) begin
        cs_dec[i] = 1'b0;
      end
    end
  end

  assign cs_n     = cs_dec;
  assign mosi     = (~&cs_dec) & tx_sh_q[DATA_W-1];
  assign tx_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign rx_valid = (state_q == ST_DONE);
  assign rx_data  = rx_data_q;

  always_comb begin
    state_d   = state_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    cs_d      = cs_q;
    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          state_d = ST_SETUP;
          tx_sh_d = tx_data;
          cs_d    = cs_sel;
          rx_sh_d = '0;
        end
      end
      ST_SETUP: begin
        if (tick) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (sample) rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
        if (shift)  tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
        if (last_edge) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (tick) begin
          state_d   = ST_DONE;
          rx_data_d = rx_sh_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      cs_q      <= '0;
    end else begin
      state_q   <= state_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      cs_q      <= cs_d;
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - four SPI modes plus an N_CS=5 instance run in lockstep against a timing/protocol model
module tb_spi_master_ctrl;

  localparam int NI = 5;

  logic       sys_clk = 1'b0;
  logic       rstn = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [2:0] cs_sel3 = 3'd0;
  logic       loop_en = 1'b1;
  logic       miso_rand = 1'b0;
  logic       miso_const = 1'b0;
  logic       rnd_bit = 1'b0;
  logic       miso_src;
  int         cyc = 0;

  logic [NI-1:0] sclk_w, mosi_w, miso_w, rxv_w, busy_w, rdy_w;
  logic [7:0]    rxd_w [NI];
  logic [3:0]    csn4 [4];
  logic [4:0]    csn5;

  int checks = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  assign miso_src = miso_rand ? rnd_bit : miso_const;

  for (genvar g = 0; g < NI; g++) begin : g_miso
    assign miso_w[g] = loop_en ? mosi_w[g] : miso_src;
  end

  for (genvar g = 0; g < 4; g++) begin : g_mode
    localparam bit P_CPOL = (g >= 2);
    localparam bit P_CPHA = (g % 2 == 1);
    spi_master_ctrl #(.DATA_W(8), .N_CS(4), .CLK_DIV(2), .CPOL(P_CPOL), .CPHA(P_CPHA)) u_dut (
      .sys_clk(sys_clk), .rstn(rstn), .tx_valid(tx_valid), .tx_ready(rdy_w[g]),
      .tx_data(tx_data), .cs_sel(cs_sel3[1:0]), .rx_valid(rxv_w[g]), .rx_data(rxd_w[g]),
      .busy(busy_w[g]), .sclk(sclk_w[g]), .mosi(mosi_w[g]), .miso(miso_w[g]), .cs_n(csn4[g]));
  end

  spi_master_ctrl #(.DATA_W(8), .N_CS(5), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0)) u_dut_cs5 (
    .sys_clk(sys_clk), .rstn(rstn), .tx_valid(tx_valid), .tx_ready(rdy_w[4]),
    .tx_data(tx_data), .cs_sel(cs_sel3), .rx_valid(rxv_w[4]), .rx_data(rxd_w[4]),
    .busy(busy_w[4]), .sclk(sclk_w[4]), .mosi(mosi_w[4]), .miso(miso_w[4]), .cs_n(csn5));

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d actual=%0h required=%0h", nm, k, cyc, act, exp);
    end
  endtask

  function automatic bit m_cpol(input int k);
    return (k == 2) || (k == 3);
  endfunction

  function automatic bit m_cpha(input int k);
    return (k == 1) || (k == 3);
  endfunction

  function automatic logic [4:0] exp_csn(input int k, input logic [2:0] s, input bit on);
    logic [4:0] r;
    r = 5'h1F;
    if (on) begin
      if (k < 4) r[s[1:0]] = 1'b0;
      else if (s < 3'd5) r[s] = 1'b0;
    end
    return r;
  endfunction

  // o = cycles since the accept cycle: 2 setup, 32 shift (16 half-periods of 2), 2 hold, then done
  function automatic bit exp_sclk(input int k, input int o);
    int p;
    p = o - 3;
    if (p < 0 || p >= 32) return m_cpol(k);
    return m_cpol(k) ^ ((p / 2) % 2 == 1);
  endfunction

  bit         started = 0;
  bit         active = 0;
  int         acc_t = 0;
  logic [7:0] acc_d = 8'h00;
  logic [2:0] acc_s = 3'd0;
  logic [7:0] exp_rx [NI];
  logic [7:0] last_rx [NI];
  logic [7:0] obs_mosi [NI];
  int         smp_n [NI];
  int         edge_n [NI];
  logic       prev_sclk [NI];
  logic       prev_miso [NI];
  int         rxv_cyc = 0;
  int         rxv4_cyc = 0;
  int         rxv_seen = 0;
  bit         cs5_low = 0;

  always @(negedge sys_clk) begin
    int o, p, h;
    bit xfer, sp;
    logic [4:0] ecs, acs;
    if (started) begin
      if (active && (cyc - acc_t) >= 38) active = 0;
      o = active ? (cyc - acc_t) : 0;
      xfer = (o >= 1) && (o <= 36);
      p = o - 3;
      if (rxv_w[0]) begin
        rxv_cyc = cyc;
        rxv_seen++;
      end
      if (rxv_w[4]) rxv4_cyc = cyc;
      if (csn5 != 5'h1F) cs5_low = 1;
      for (int k = 0; k < NI; k++) begin
        ecs = exp_csn(k, acc_s, xfer);
        acs = (k < 4) ? {1'b1, csn4[k]} : csn5;
        chk("tx_ready", k, 32'(rdy_w[k]), 32'(!active));
        chk("busy", k, 32'(busy_w[k]), 32'(active));
        chk("rx_valid", k, 32'(rxv_w[k]), 32'(o == 37));
        chk("cs_n", k, 32'(acs), 32'(ecs));
        chk("sclk", k, 32'(sclk_w[k]), 32'(exp_sclk(k, o)));
        if (ecs == 5'h1F) chk("mosi_idle", k, 32'(mosi_w[k]), 32'd0);
        if (p >= 2 && p <= 32 && (p % 2) == 0) begin
          h = p / 2;
          sp = m_cpha(k) ? ((h % 2) == 0) : ((h % 2) == 1);
          if (sp && smp_n[k] < 8) begin
            chk("mosi_bit", k, 32'(mosi_w[k]), (ecs == 5'h1F) ? 32'd0 : 32'(acc_d[7 - smp_n[k]]));
            obs_mosi[k] = {obs_mosi[k][6:0], mosi_w[k]};
            exp_rx[k] = {exp_rx[k][6:0], prev_miso[k]};
            smp_n[k]++;
          end
        end
        if (o >= 1 && sclk_w[k] !== prev_sclk[k]) edge_n[k]++;
        if (o == 37) begin
          chk("sclk_edges", k, 32'(edge_n[k]), 32'd16);
          chk("rx_data", k, 32'(rxd_w[k]), 32'(exp_rx[k]));
          last_rx[k] = exp_rx[k];
        end else begin
          chk("rx_hold", k, 32'(rxd_w[k]), 32'(last_rx[k]));
        end
        prev_sclk[k] = sclk_w[k];
        prev_miso[k] = miso_w[k];
      end
    end
    if (!rstn) begin
      started = 1;
      active = 0;
      for (int k = 0; k < NI; k++) last_rx[k] = 8'h00;
    end else if (started && !active && tx_valid) begin
      active = 1;
      acc_t = cyc;
      acc_d = tx_data;
      acc_s = cs_sel3;
      cs5_low = 0;
      for (int k = 0; k < NI; k++) begin
        exp_rx[k] = 8'h00;
        obs_mosi[k] = 8'h00;
        smp_n[k] = 0;
        edge_n[k] = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge sys_clk);
      #1;
      rnd_bit = 1'($urandom);
    end
  end

  logic [3:0] mid_csn;

  task automatic tick1();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic xfer(input logic [7:0] d, input logic [2:0] s);
    int n;
    tx_data = d;
    cs_sel3 = s;
    tx_valid = 1'b1;
    tick1();
    tx_valid = 1'b0;
    n = 0;
    while (!rxv_w[0] && n < 100) begin
      tx_data = 8'($urandom);
      cs_sel3 = 3'($urandom);
      if (n == 10) mid_csn = csn4[0];
      tick1();
      n++;
    end
    chk("xfer_timeout", 0, 32'(n < 100), 32'd1);
    tick1();
  endtask

  initial begin
    int c1, c2, n;
    logic [7:0] r1;
    repeat (3) tick1();
    rstn = 1'b1;
    tick1();
    chk("reset_csn", 0, 32'(csn4[0]), 32'hF);
    chk("reset_sclk", 0, 32'(sclk_w), 32'b01100);
    chk("reset_ready", 0, 32'(rdy_w), 32'h1F);
    chk("reset_rxd", 0, 32'(rxd_w[0]), 32'h0);

    // loopback 0xA5 to slave 1
    loop_en = 1'b1;
    xfer(8'hA5, 3'd1);
    for (int k = 0; k < NI; k++) chk("loop_a5", k, 32'(rxd_w[k]), 32'hA5);
    chk("a5_cs_n", 0, 32'(mid_csn), 32'hD);
    chk("a5_latency", 0, 32'(rxv_cyc - acc_t), 32'd37);

    // constant miso levels
    loop_en = 1'b0;
    miso_rand = 1'b0;
    miso_const = 1'b1;
    xfer(8'h00, 3'd2);
    for (int k = 0; k < NI; k++) chk("miso1_rx", k, 32'(rxd_w[k]), 32'hFF);
    miso_const = 1'b0;
    xfer(8'hFF, 3'd1);
    for (int k = 0; k < NI; k++) chk("miso0_rx", k, 32'(rxd_w[k]), 32'h00);
    for (int k = 0; k < NI; k++) chk("mosi_seq_ff", k, 32'(obs_mosi[k]), 32'hFF);

    // every mode loops 0x3C
    loop_en = 1'b1;
    xfer(8'h3C, 3'd0);
    for (int k = 0; k < NI; k++) chk("mode_3c", k, 32'(rxd_w[k]), 32'h3C);

    // back-to-back with tx_valid held high
    tx_data = 8'h11;
    cs_sel3 = 3'd2;
    tx_valid = 1'b1;
    tick1();
    tx_data = 8'h22;
    cs_sel3 = 3'd3;
    n = 0;
    while (!rxv_w[0] && n < 100) begin tick1(); n++; end
    c1 = cyc;
    r1 = rxd_w[0];
    tick1();
    tick1();
    tx_valid = 1'b0;
    n = 0;
    while (!rxv_w[0] && n < 100) begin tick1(); n++; end
    c2 = cyc;
    chk("b2b_first", 0, 32'(r1), 32'h11);
    chk("b2b_second", 0, 32'(rxd_w[0]), 32'h22);
    chk("b2b_spacing", 0, 32'(c2 - c1), 32'd38);
    tick1();

    // reset at the 7th sclk edge
    tx_data = 8'hC3;
    cs_sel3 = 3'd3;
    tx_valid = 1'b1;
    tick1();
    tx_valid = 1'b0;
    repeat (15) tick1();
    rstn = 1'b0;
    tick1();
    rstn = 1'b1;
    rxv_seen = 0;
    chk("abort_csn", 0, 32'(csn4[0]), 32'hF);
    chk("abort_sclk", 0, 32'(sclk_w), 32'b01100);
    chk("abort_busy", 0, 32'(busy_w), 32'h0);
    repeat (40) tick1();
    chk("abort_no_rxv", 0, 32'(rxv_seen), 32'd0);
    chk("abort_rxd", 0, 32'(rxd_w[0]), 32'h0);

    // out-of-range select on the N_CS=5 instance
    xfer(8'h96, 3'd5);
    chk("oor_cs_n", 4, 32'(cs5_low), 32'd0);
    chk("oor_latency", 4, 32'(rxv4_cyc - acc_t), 32'd37);
    chk("oor_rx", 4, 32'(rxd_w[4]), 32'h00);
    chk("oor_other", 0, 32'(rxd_w[0]), 32'h96);

    // randomized traffic
    miso_rand = 1'b1;
    for (int i = 0; i < 25; i++) begin
      loop_en = 1'($urandom);
      repeat ($urandom_range(0, 3)) tick1();
      xfer(8'($urandom), 3'($urandom));
    end
    repeat (3) tick1();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule
